pipelined_write_rx: RTL

PIPELINED_WRITE_RX -- requirements
Module: pipelined_write_rx

---
 rtl/pipelined_write_rx_pkg.sv | 78 +++++++
 rtl/pipelined_write_rx_if.sv | 21 ++
 rtl/pipelined_write_out_buf.sv | 37 +++
 rtl/pipelined_write_rx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pipelined_write_rx_pkg.sv
// Shared types for the pipelined write receiver.
//   write_cmd__st       : command cycle, read from in_bits while idle
//   write_data__st      : data cycle, read from in_bits while collecting
//   pipelined_write__st : assembled transaction (command + four beat slots)
//   pwr_err__st         : error pulse vector
package test_pkg_b;

   localparam int unsigned MAX_WR_CYCLES = 4;
   localparam int unsigned IN_BITS_W     = 10;

   typedef enum logic [2:0] {
      STD          = 3'd0,
      MULTI_WDONE  = 3'd1,
      SINGLE_WDONE = 3'd2
   } WRITE_TYPE__ET;

   typedef enum logic [1:0] {
      CT_IDLE  = 2'd0,
      CT_VALID = 2'd1,
      CT_DONE  = 2'd2,
      CT_RSVD  = 2'd3
   } CYCLE_TYPE__ET;

   // num_cycles == 0 encodes a full MAX_WR_CYCLES-beat transfer
   typedef struct packed {
      logic [3:0] rsvd;
      logic [2:0] write_type;
      logic [1:0] num_cycles;
      logic       val;
   } write_cmd__st;

   typedef struct packed {
      logic [1:0] cycle_type;
      logic [7:0] dat;
   } write_data__st;

   typedef struct packed {
      write_cmd__st  cmd_cycle__s;
      write_data__st dat3;
      write_data__st dat2;
      write_data__st dat1;
      write_data__st dat0;
   } pipelined_write__st;

   typedef struct packed {
      logic early_done;
      logic no_done;
      logic overflow;
      logic bad_type;
      logic timeout;
   } pwr_err__st;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } pwr_state__et;

   // True for the write types the receiver understands
   function automatic logic valid_write_type(logic [2:0] wt);
      return (wt == STD) || (wt == MULTI_WDONE) || (wt == SINGLE_WDONE);
   endfunction

   // Returns pw with beat slot idx replaced by d
   function automatic pipelined_write__st set_slot(pipelined_write__st pw,
                                                   logic [1:0] idx,
                                                   write_data__st d);
      pipelined_write__st r;
      r = pw;
      case (idx)
         2'd0:    r.dat0 = d;
         2'd1:    r.dat1 = d;
         2'd2:    r.dat2 = d;
         default: r.dat3 = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pipelined_write_rx_if.sv
// Bus bundle between the cycle producer/transaction consumer and the receiver.
//   in_vld/in_bits : incoming command/data cycles
//   xact_vld/xact_rdy/xact : assembled transaction handshake
//   wdone, err     : single-cycle status pulses
interface pipelined_write_rx_if;
   import test_pkg_b::*;

   logic                 in_vld;
   logic [IN_BITS_W-1:0] in_bits;
   logic                 xact_vld;
   logic                 xact_rdy;
   pipelined_write__st   xact;
   logic                 wdone;
   pwr_err__st           err;

   modport master (output in_vld, in_bits, xact_rdy,
                   input  xact_vld, xact, wdone, err);

   modport slave  (input  in_vld, in_bits, xact_rdy,
                   output xact_vld, xact, wdone, err);
endinterface

// File: rtl/pipelined_write_out_buf.sv
// One-entry valid/ready holding register for finished transactions.
//   load/load_data : offer a finished transaction this cycle
//   rdy            : consumer ready
//   vld/data       : registered holding slot
//   accepted_c     : offer is taken (slot empty or drained this cycle)
//   overflow_c     : offer arrives while the slot is held and not drained
module pipelined_write_out_buf
   import test_pkg_b::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  pipelined_write__st load_data,
   input  logic               rdy,
   output logic               vld,
   output pipelined_write__st data,
   output logic               accepted_c,
   output logic               overflow_c
);

   assign accepted_c = load && (!vld || rdy);
   assign overflow_c = load && vld && !rdy;

   // Slot register: a load in the handshake cycle replaces the consumed entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         data <= '0;
      end else if (accepted_c) begin
         vld  <= 1'b1;
         data <= load_data;
      end else if (vld && rdy) begin
         vld  <= 1'b0;
      end
   end

endmodule

// File: rtl/pipelined_write_rx.sv
// Receives a command cycle followed by 1..4 data beats, assembles them into a
// pipelined_write__st and hands it out through a one-entry holding register.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : in_vld/in_bits input cycles, xact_vld/xact_rdy/xact
//                    output handshake, wdone pulse, err pulse vector
// Status pulses (wdone, err) are registered and appear the cycle after the
// input cycle that caused them.
module pipelined_write_rx
   import test_pkg_b::*;
#(
   parameter int unsigned BUBBLE_TIMEOUT = 15
)
(
   input  logic             clk,
   input  logic             rst_n,
   pipelined_write_rx_if.slave bus
);

   localparam int unsigned BEAT_W = 2;
   localparam int unsigned EXP_W  = 3;
   localparam int unsigned BUB_W  = 4;
   localparam logic [BUB_W-1:0] BUB_LAST = BUB_W'(BUBBLE_TIMEOUT - 1);

   pwr_state__et       state, state_nxt;
   pipelined_write__st asm_q, asm_nxt, full_c;
   logic [BEAT_W-1:0]  beat_cnt, beat_cnt_nxt;
   logic [EXP_W-1:0]   beats_exp, beats_exp_nxt;
   logic [BUB_W-1:0]   bubble_cnt, bubble_nxt;
   logic               wdone_nxt;
   pwr_err__st         err_nxt;
   logic               load_c, accepted_c, overflow_c;
   write_cmd__st       cmd_c;
   write_data__st      data_c;
   logic               beat_c, last_c;
   logic [2:0]         wt_c;

   assign cmd_c  = write_cmd__st'(bus.in_bits);
   assign data_c = write_data__st'(bus.in_bits);
   assign beat_c = bus.in_vld &&
                   ((data_c.cycle_type == CT_VALID) || (data_c.cycle_type == CT_DONE));
   assign last_c = (EXP_W'(beat_cnt) == (beats_exp - EXP_W'(1)));
   assign full_c = set_slot(asm_q, beat_cnt, data_c);
   // Unknown write types behave as STD from the command onward
   assign wt_c   = valid_write_type(cmd_c.write_type) ? cmd_c.write_type : STD;

   // Next-state, datapath and pulse decode
   always_comb begin
      state_nxt     = state;
      asm_nxt       = asm_q;
      beat_cnt_nxt  = beat_cnt;
      beats_exp_nxt = beats_exp;
      bubble_nxt    = bubble_cnt;
      wdone_nxt     = 1'b0;
      err_nxt       = '0;
      load_c        = 1'b0;

      case (state)
         IDLE: begin
            if (bus.in_vld && cmd_c.val) begin
               err_nxt.bad_type               = !valid_write_type(cmd_c.write_type);
               asm_nxt                        = '0;
               asm_nxt.cmd_cycle__s           = cmd_c;
               asm_nxt.cmd_cycle__s.write_type = wt_c;
               beats_exp_nxt = (cmd_c.num_cycles == '0) ? EXP_W'(MAX_WR_CYCLES)
                                                        : EXP_W'(cmd_c.num_cycles);
               beat_cnt_nxt  = '0;
               bubble_nxt    = '0;
               state_nxt     = COLLECT;
            end
         end

         COLLECT: begin
            if (beat_c) begin
               bubble_nxt = '0;
               if (last_c) begin
                  // Final beat: offer the full transaction to the holding slot
                  load_c          = 1'b1;
                  err_nxt.no_done = (data_c.cycle_type == CT_VALID);
                  err_nxt.overflow = overflow_c;
                  wdone_nxt       = accepted_c && (asm_q.cmd_cycle__s.write_type != STD);
                  beat_cnt_nxt    = '0;
                  state_nxt       = IDLE;
               end else if (data_c.cycle_type == CT_DONE) begin
                  err_nxt.early_done = 1'b1;
                  beat_cnt_nxt       = '0;
                  state_nxt          = IDLE;
               end else begin
                  asm_nxt      = full_c;
                  beat_cnt_nxt = beat_cnt + BEAT_W'(1);
                  wdone_nxt    = (asm_q.cmd_cycle__s.write_type == MULTI_WDONE);
               end
            end else if (bubble_cnt == BUB_LAST) begin
               err_nxt.timeout = 1'b1;
               bubble_nxt      = '0;
               beat_cnt_nxt    = '0;
               state_nxt       = IDLE;
            end else begin
               bubble_nxt = bubble_cnt + BUB_W'(1);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // State, assembly and pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         asm_q      <= '0;
         beat_cnt   <= '0;
         beats_exp  <= '0;
         bubble_cnt <= '0;
         bus.wdone  <= 1'b0;
         bus.err    <= '0;
      end else begin
         state      <= state_nxt;
         asm_q      <= asm_nxt;
         beat_cnt   <= beat_cnt_nxt;
         beats_exp  <= beats_exp_nxt;
         bubble_cnt <= bubble_nxt;
         bus.wdone  <= wdone_nxt;
         bus.err    <= err_nxt;
      end
   end

   pipelined_write_out_buf u_out_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_c),
      .load_data  (full_c),
      .rdy        (bus.xact_rdy),
      .vld        (bus.xact_vld),
      .data       (bus.xact),
      .accepted_c (accepted_c),
      .overflow_c (overflow_c)
   );

endmodule
